umstr_reg_arb: RTL

- Two-port arbiter that shares one downstream register bus (UDP master control/status register file) between two register-interface requesters.
- Port 0 is the AXI-lite register bridge. Port 1 is the internal config/status sequencer.
- Each port has independent write and read channels, so there are four request sources. Sources are served one transaction at a time, round-robin.
- The arbiter drives upstream wait while a request is queued or the target stalls. It completes any unacknowledged transaction with a local timeout.

---
 rtl/umstr_reg_arb.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/umstr_reg_arb.sv
// Round-robin arbiter sharing one downstream register bus between two requesters,
// each with independent write and read channels, with a local transaction timeout.
module umstr_reg_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] s0_reg_wr_addr,
    input  logic [DATA_WIDTH-1:0] s0_reg_wr_data,
    input  logic [STRB_WIDTH-1:0] s0_reg_wr_strb,
    input  logic                  s0_reg_wr_en,
    output logic                  s0_reg_wr_wait,
    output logic                  s0_reg_wr_ack,
    input  logic [ADDR_WIDTH-1:0] s0_reg_rd_addr,
    input  logic                  s0_reg_rd_en,
    output logic [DATA_WIDTH-1:0] s0_reg_rd_data,
    output logic                  s0_reg_rd_wait,
    output logic                  s0_reg_rd_ack,
    input  logic [ADDR_WIDTH-1:0] s1_reg_wr_addr,
    input  logic [DATA_WIDTH-1:0] s1_reg_wr_data,
    input  logic [STRB_WIDTH-1:0] s1_reg_wr_strb,
    input  logic                  s1_reg_wr_en,
    output logic                  s1_reg_wr_wait,
    output logic                  s1_reg_wr_ack,
    input  logic [ADDR_WIDTH-1:0] s1_reg_rd_addr,
    input  logic                  s1_reg_rd_en,
    output logic [DATA_WIDTH-1:0] s1_reg_rd_data,
    output logic                  s1_reg_rd_wait,
    output logic                  s1_reg_rd_ack,
    output logic [ADDR_WIDTH-1:0] m_reg_wr_addr,
    output logic [DATA_WIDTH-1:0] m_reg_wr_data,
    output logic [STRB_WIDTH-1:0] m_reg_wr_strb,
    output logic                  m_reg_wr_en,
    input  logic                  m_reg_wr_wait,
    input  logic                  m_reg_wr_ack,
    output logic [ADDR_WIDTH-1:0] m_reg_rd_addr,
    output logic                  m_reg_rd_en,
    input  logic [DATA_WIDTH-1:0] m_reg_rd_data,
    input  logic                  m_reg_rd_wait,
    input  logic                  m_reg_rd_ack,
    output logic                  timeout_evt,
    output logic [1:0]            grant_src
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            ptr_q, ptr_d;
    logic [1:0]            src_q, src_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [STRB_WIDTH-1:0] strb_q, strb_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [7:0]            tcnt_q, tcnt_d;
    logic                  m_wr_en_q, m_wr_en_d;
    logic                  m_rd_en_q, m_rd_en_d;
    logic [3:0]            ack_q, ack_d;
    logic                  tout_q, tout_d;
    logic                  run_q;

    logic [3:0] req;
    logic [3:0] wait_v;
    logic [1:0] win;
    logic [1:0] idx;
    logic       found;
    logic       m_ack;
    logic       m_wait;

    // Source index: bit 1 selects the port, bit 0 selects read (1) or write (0).
    assign req    = {s1_reg_rd_en, s1_reg_wr_en, s0_reg_rd_en, s0_reg_wr_en};
    assign m_ack  = src_q[0] ? m_reg_rd_ack : m_reg_wr_ack;
    assign m_wait = src_q[0] ? m_reg_rd_wait : m_reg_wr_wait;

    always_comb begin
        win   = ptr_q;
        idx   = ptr_q;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + i[1:0];
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        src_d     = src_q;
        addr_d    = addr_q;
        data_d    = data_q;
        strb_d    = strb_q;
        rd_data_d = rd_data_q;
        tcnt_d    = tcnt_q;
        m_wr_en_d = m_wr_en_q;
        m_rd_en_d = m_rd_en_q;
        ack_d     = '0;
        tout_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d   = XFER;
                    src_d     = win;
                    ptr_d     = win + 2'd1;
                    tcnt_d    = '0;
                    m_wr_en_d = ~win[0];
                    m_rd_en_d = win[0];
                    data_d    = '0;
                    strb_d    = '0;
                    case (win)
                        2'd0: begin
                            addr_d = s0_reg_wr_addr;
                            data_d = s0_reg_wr_data;
                            strb_d = s0_reg_wr_strb;
                        end
                        2'd1: addr_d = s0_reg_rd_addr;
                        2'd2: begin
                            addr_d = s1_reg_wr_addr;
                            data_d = s1_reg_wr_data;
                            strb_d = s1_reg_wr_strb;
                        end
                        default: addr_d = s1_reg_rd_addr;
                    endcase
                end
            end
            XFER: begin
                // A real ack wins over a timeout landing on the same edge.
                if (m_ack) begin
                    state_d   = DONE;
                    m_wr_en_d = 1'b0;
                    m_rd_en_d = 1'b0;
                    ack_d     = 4'b0001 << src_q;
                    if (src_q[0]) rd_data_d = m_reg_rd_data;
                end else if (m_wait) begin
                    tcnt_d = '0;
                end else if (tcnt_q == 8'(TIMEOUT - 1)) begin
                    state_d   = DONE;
                    m_wr_en_d = 1'b0;
                    m_rd_en_d = 1'b0;
                    ack_d     = 4'b0001 << src_q;
                    tout_d    = 1'b1;
                    if (src_q[0]) rd_data_d = '0;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            src_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            rd_data_q <= '0;
            tcnt_q    <= '0;
            m_wr_en_q <= 1'b0;
            m_rd_en_q <= 1'b0;
            ack_q     <= '0;
            tout_q    <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            src_q     <= src_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
            rd_data_q <= rd_data_d;
            tcnt_q    <= tcnt_d;
            m_wr_en_q <= m_wr_en_d;
            m_rd_en_q <= m_rd_en_d;
            ack_q     <= ack_d;
            tout_q    <= tout_d;
            run_q     <= 1'b1;
        end
    end

    // run_q keeps wait low while in reset even if requesters already hold en.
    always_comb begin
        wait_v = '0;
        for (int i = 0; i < 4; i++) begin
            wait_v[i] = run_q &&
                ((req[i] && !((state_q != IDLE) && (src_q == i[1:0]))) ||
                 ((state_q == XFER) && (src_q == i[1:0]) && m_wait));
        end
    end

    assign s0_reg_wr_wait = wait_v[0];
    assign s0_reg_rd_wait = wait_v[1];
    assign s1_reg_wr_wait = wait_v[2];
    assign s1_reg_rd_wait = wait_v[3];
    assign s0_reg_wr_ack  = ack_q[0];
    assign s0_reg_rd_ack  = ack_q[1];
    assign s1_reg_wr_ack  = ack_q[2];
    assign s1_reg_rd_ack  = ack_q[3];
    assign s0_reg_rd_data = rd_data_q;
    assign s1_reg_rd_data = rd_data_q;
    assign m_reg_wr_addr  = addr_q;
    assign m_reg_wr_data  = data_q;
    assign m_reg_wr_strb  = strb_q;
    assign m_reg_wr_en    = m_wr_en_q;
    assign m_reg_rd_addr  = addr_q;
    assign m_reg_rd_en    = m_rd_en_q;
    assign timeout_evt    = tout_q;
    assign grant_src      = src_q;

endmodule
